// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// It runs the mult/multu/div/divu operations beside the EX-stage ALU. The ALU then
// needs no combinational 64-bit multiplier or divider. The unit also serves mthi/mtlo
// writes and exposes HI/LO directly for mfhi/mflo.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start, op      launch an operation when idle
//                  op: 00 mult, 01 multu, 10 div, 11 divu
//   x, y           multiplicand/dividend, multiplier/divisor
//   mthi, mtlo     write wdata to HI and/or LO (idle only; start has priority)
//   wdata          data for mthi/mtlo
//   busy           operation in flight (registered, equals state != IDLE)
//   done           one-cycle pulse after HI/LO were written by an operation
//   div_by_zero    valid with done: the last div/divu had y == 0
//   hi, lo         HI and LO registers
//
// Timing: start is sampled at edge t0. The unit runs WIDTH CALC steps at edges
// t0+1 .. t0+WIDTH. FIX takes two cycles: the first applies sign correction and the
// second commits HI/LO, so the results appear at t0+WIDTH+2. A division by zero
// skips CALC and commits at t0+2.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;      // product / quotient must be negated
  logic             rneg_q, rneg_d;    // remainder must be negated (dividend sign)
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Multiply: {acc, a} is the running product, b is |multiplicand|.
  // Divide:   a shifts the dividend out and the quotient in, acc is the partial
  //           remainder, b is |divisor|.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_x, abs_y;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that left one
    // unassigned would infer a latch.
    state_d       = state_q;
    is_div_d      = is_div_q;
    neg_d         = neg_q;
    rneg_d        = rneg_q;
    dz_d          = dz_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;

    // Two's-complement negation of the most negative value returns the same bit
    // pattern. Read as unsigned, that is its correct magnitude, so 0x80000000 needs
    // no special case.
    signed_op = ~op[0];
    abs_x     = (signed_op && x[WIDTH-1]) ? -x : x;
    abs_y     = (signed_op && y[WIDTH-1]) ? -y : y;

    mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_neg  = -{acc_q, a_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          cnt_d    = '0;
          if (op[1] && (y == '0)) begin
            // The divide-by-zero result is known up front. It goes through FIX with
            // both sign flags cleared, so FIX leaves it unchanged.
            acc_d   = x;
            a_d     = '1;
            b_d     = '0;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            dz_d    = 1'b1;
            state_d = S_FIX;
          end else begin
            a_d     = op[1] ? abs_x : abs_y;
            b_d     = op[1] ? abs_y : abs_x;
            acc_d   = '0;
            neg_d   = signed_op & (x[WIDTH-1] ^ y[WIDTH-1]);
            rneg_d  = op[1] & signed_op & x[WIDTH-1];
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          // Restoring step: keep the trial subtraction only when it does not borrow.
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: conditionally add, then shift the product right with its carry.
          acc_d = mul_sum[WIDTH:1];
          a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
          if (!is_div_q) begin
            if (neg_q) {acc_d, a_d} = prod_neg;
          end else begin
            if (neg_q)  a_d   = -a_q;
            if (rneg_q) acc_d = -acc_q;
          end
        end else begin
          hi_d          = acc_q;
          lo_d          = a_q;
          done_d        = 1'b1;
          div_by_zero_d = dz_q;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: the datapath registers are reset as well. A reset in mid-operation
  // therefore leaves no partial product or remainder behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rneg_q        <= 1'b0;
      dz_q          <= 1'b0;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments, so all flops sample the
      // values from before the edge.
      state_q       <= state_d;
      is_div_q      <= is_div_d;
      neg_q         <= neg_d;
      rneg_q        <= rneg_d;
      dz_q          <= dz_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo. The stimulus pushes the expected HI/LO/flag
// values into a scoreboard queue when it launches an operation. A monitor pops the
// queue and compares whenever done is seen.
module tb_muldiv_hilo;

  localparam int W = 32;
  localparam int LAT = W + 2;
  localparam int LAT_DZ = 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x, y;
  logic         mthi, mtlo;
  logic [W-1:0] wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .x           (x),
    .y           (y),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("done_without_busy", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result_hi", {32'd0, hi}, {32'd0, e.hi});
          check("result_lo", {32'd0, lo}, {32'd0, e.lo});
          check("result_dz", {63'd0, div_by_zero}, {63'd0, e.dz});
        end
      end
    end
  end

  // Launches one operation and measures start-to-done latency. The measurement is
  // bounded at 100 cycles.
  // interfere: re-pulses start (sampled at t0+5) and mthi (sampled at t0+6).
  // collide:   asserts mthi in the same cycle as start. hold_hi is the HI value
  //            that must survive that collision.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] xi, input logic [W-1:0] yi,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat, input bit interfere, input bit collide,
                        input logic [W-1:0] hold_hi);
    int n;
    bit got_done;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    x     = xi;
    y     = yi;
    if (collide) begin
      mthi  = 1'b1;
      wdata = 32'hDEADBEEF;
    end
    sb.push_back('{hi: ehi, lo: elo, dz: edz});
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    if (collide) check("collide_hi_kept", {32'd0, hi}, {32'd0, hold_hi});
    n        = 0;
    got_done = 1'b0;
    busy_ok  = 1'b1;
    while (n < 100 && !got_done) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got_done = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (interfere) begin
        if (n == 4) begin
          start = 1'b1;
          op    = 2'b01;
          x     = 32'h5;
          y     = 32'h6;
        end
        if (n == 5) begin
          start = 1'b0;
          mthi  = 1'b1;
          wdata = 32'hBAD0BAD0;
        end
        if (n == 6) mthi = 1'b0;
      end
    end
    check("latency", 64'(n), 64'(lat));
    check("busy_held", {63'd0, busy_ok}, 64'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    x     = '0;
    y     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    #12;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiplies: signed, unsigned, most-negative operands.
    run_op(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT, 0, 0, '0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT, 0, 0, '0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT, 0, 0, '0);

    // Divides: remainder carries the dividend's sign; unsigned view of the same bits.
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT, 0, 0, '0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, LAT, 0, 0, '0);
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT, 0, 0, '0);

    // Divide by zero, then signed overflow (which also clears the flag).
    run_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, LAT_DZ, 0, 0, '0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT, 0, 0, '0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, LAT_DZ, 0, 0, '0);

    // start and mthi while busy are ignored.
    run_op(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, LAT, 1, 0, '0);

    // mthi and mtlo together, then mtlo alone.
    @(negedge clk);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_both_hi", {32'd0, hi}, 64'h12345678);
    check("mt_both_lo", {32'd0, lo}, 64'h12345678);
    check("mt_no_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    mtlo  = 1'b1;
    wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'hCAFEF00D);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);

    // start and mthi in the same idle cycle: start wins.
    run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, LAT, 0, 1, 32'h12345678);

    // Set the flag so that the reset check below has something to clear.
    run_op(2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, LAT_DZ, 0, 0, '0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    x     = 32'd1000;
    y     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // The unit works normally after the reset.
    run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, LAT, 0, 0, '0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
